// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file and its scoreboard.
package rf_pkg;

    // Default geometry of the register file
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    // Architectural address of the register that may be hardwired to zero
    localparam int REG_ZERO = 0;

    // Kind of access a read port resolves to in a given cycle
    typedef enum logic [1:0] {
        RD_ARRAY  = 2'd0,
        RD_BYPASS = 2'd1,
        RD_ZERO   = 2'd2
    } rd_src_e;

    // True when an address names the hardwired-zero register and that feature is enabled
    function automatic logic is_zero_reg(input int addr, input bit r0_zero);
        return r0_zero && (addr == REG_ZERO);
    endfunction

    // Pick the source of a read port: hardwired zero overrides bypass, bypass overrides the array
    function automatic rd_src_e rd_source(input logic zero_hit, input logic byp_hit);
        if (zero_hit)
            return RD_ZERO;
        else if (byp_hit)
            return RD_BYPASS;
        else
            return RD_ARRAY;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// Produces the WAW issue handshake and the RAW busy flags for both read ports.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit BYPASS  = 1'b1,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              iss_ready,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    logic wr_zero;
    logic iss_zero;
    logic rda_zero;
    logic rdb_zero;
    logic wr_hit_iss;
    logic wr_hit_a;
    logic wr_hit_b;

    assign wr_zero    = is_zero_reg(int'(wr_addr), R0_ZERO);
    assign iss_zero   = is_zero_reg(int'(iss_addr), R0_ZERO);
    assign rda_zero   = is_zero_reg(int'(rd_addr_a), R0_ZERO);
    assign rdb_zero   = is_zero_reg(int'(rd_addr_b), R0_ZERO);

    assign wr_hit_iss = wr_en && (wr_addr == iss_addr);
    assign wr_hit_a   = BYPASS && wr_en && (wr_addr == rd_addr_a);
    assign wr_hit_b   = BYPASS && wr_en && (wr_addr == rd_addr_b);

    // A writeback completing this cycle retires the hazard, so the issue may proceed
    assign iss_ready = !pending[iss_addr] || wr_hit_iss || iss_zero;

    // A read is only stalled if the value it needs is neither in flight on the bypass nor constant
    assign busy_a = pending[rd_addr_a] && !wr_hit_a && !rda_zero;
    assign busy_b = pending[rd_addr_b] && !wr_hit_b && !rdb_zero;

    // Next pending vector: writeback clears first, an accepted issue sets afterwards so set wins
    always_comb begin
        pending_nxt = pending;
        if (wr_en && !wr_zero)
            pending_nxt[wr_addr] = 1'b0;
        if (iss_en && iss_ready && !iss_zero)
            pending_nxt[iss_addr] = 1'b1;
    end

    // Pending bits, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

endmodule

// File: rtl/regfile_param_sb.sv
// Parametrised register file: two combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired-zero R0 and a pending-write
// scoreboard used by decode to stall on RAW/WAW hazards.
module regfile_param_sb
    import rf_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit BYPASS  = 1'b1,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    logic    wr_zero;
    logic    byp_a;
    logic    byp_b;
    rd_src_e src_a;
    rd_src_e src_b;

    assign wr_zero = is_zero_reg(int'(wr_addr), R0_ZERO);
    assign byp_a   = BYPASS && wr_en && (wr_addr == rd_addr_a);
    assign byp_b   = BYPASS && wr_en && (wr_addr == rd_addr_b);
    assign src_a   = rd_source(is_zero_reg(int'(rd_addr_a), R0_ZERO), byp_a);
    assign src_b   = rd_source(is_zero_reg(int'(rd_addr_b), R0_ZERO), byp_b);

    // Register storage; writes to a hardwired-zero R0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_en && !wr_zero) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port A: zero, forwarded writeback data, or stored value
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        case (src_a)
            RD_ZERO:   rd_data_a = '0;
            RD_BYPASS: rd_data_a = wr_data;
            default:   rd_data_a = regs[rd_addr_a];
        endcase
    end

    // Read port B: same selection as port A, fully independent
    always_comb begin
        rd_data_b = regs[rd_addr_b];
        case (src_b)
            RD_ZERO:   rd_data_b = '0;
            RD_BYPASS: rd_data_b = wr_data;
            default:   rd_data_b = regs[rd_addr_b];
        endcase
    end

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .R0_ZERO (R0_ZERO)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .iss_ready (iss_ready),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

endmodule

// File: tb/tb_regfile_param_sb.sv
// Testbench for regfile_param_sb: three instances (bypass, no bypass, bypass+zero R0)
// share stimulus; the bypass instance is checked against a behavioural model via a queue.
module tb_regfile_param_sb;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic        iss_en;
    logic [2:0]  iss_addr;

    logic [15:0] rda1, rdb1, rda0, rdb0, rdaz, rdbz;
    logic        ba1, bb1, ir1, ba0, bb0, ir0, baz, bbz, irz;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ba;
        logic        bb;
        logic        ir;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_param_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .R0_ZERO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda1), .rd_addr_b(rd_addr_b), .rd_data_b(rdb1),
        .busy_a(ba1), .busy_b(bb1), .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(ir1));

    regfile_param_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .R0_ZERO(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda0), .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
        .busy_a(ba0), .busy_b(bb0), .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(ir0));

    regfile_param_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .R0_ZERO(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rdaz), .rd_addr_b(rd_addr_b), .rd_data_b(rdbz),
        .busy_a(baz), .busy_b(bbz), .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(irz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the BYPASS=1, R0_ZERO=0 instance
    logic [15:0] m_reg [8];
    logic [7:0]  m_pend;
    logic        m_rdy;

    assign m_rdy = !m_pend[iss_addr] || (wr_en && wr_addr == iss_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_reg[i] <= 16'h0;
            m_pend <= 8'h0;
        end else begin
            if (wr_en) begin
                m_reg[wr_addr]  <= wr_data;
                m_pend[wr_addr] <= 1'b0;
            end
            if (iss_en && m_rdy) m_pend[iss_addr] <= 1'b1;
        end
    end

    function automatic exp_t predict();
        exp_t r;
        logic hit_a, hit_b;
        hit_a = wr_en && (wr_addr == rd_addr_a);
        hit_b = wr_en && (wr_addr == rd_addr_b);
        r.a  = hit_a ? wr_data : m_reg[rd_addr_a];
        r.b  = hit_b ? wr_data : m_reg[rd_addr_b];
        r.ba = m_pend[rd_addr_a] && !hit_a;
        r.bb = m_pend[rd_addr_b] && !hit_b;
        r.ir = m_rdy;
        return r;
    endfunction

    // Apply one cycle of stimulus just after the rising edge and queue the expected outputs
    task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic ie, input logic [2:0] ia);
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb;
        iss_en = ie; iss_addr = ia;
        #0;
        q.push_back(predict());
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0, 3'(i));
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                         i, rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
            end
            n_checks++;
            if ({rda0, rdb0, rdaz, rdbz, ba0, bb0, baz, bbz, ir0, irz} !== {64'h0, 4'b0, 2'b11}) begin
                n_fail++;
                $display("FAIL reset_others[%0d]: got nb a=%h b=%h z a=%h b=%h busy=%b%b%b%b ir=%b%b, want zeros and ir=11",
                         i, rda0, rdb0, rdaz, rdbz, ba0, bb0, baz, bbz, ir0, irz);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        // Same-cycle read of the register being written
        drive(1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 1'b0, 3'd0);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL wr_bypass: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        n_checks++;
        if ({rda0, rdb0} !== {16'h0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL wr_nobypass: got a=%h b=%h, want a=0000 b=0000", rda0, rdb0);
        end
        // Next cycle both ports see the stored value on every instance
        drive(1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b0, 3'd0);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL rd_after_wr: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        n_checks++;
        if ({rda0, rdb0, rda1} !== {16'h1234, 16'h1234, 16'h1234}) begin
            n_fail++;
            $display("FAIL rd_after_wr_const: got nb a=%h b=%h byp a=%h, want 1234 1234 1234", rda0, rdb0, rda1);
        end
    endtask

    task automatic test_r0_zero();
        drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b0, 3'd0);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL r0_write_model: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        n_checks++;
        if ({rdaz, rdbz} !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_bypass_override: got a=%h b=%h, want 0000 0000", rdaz, rdbz);
        end
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 3'd0);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL r0_issue_model: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        n_checks++;
        if ({rdaz, irz, baz} !== {16'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL r0_read_after_write: got a=%h ir=%b busy=%b, want 0000 1 0", rdaz, irz, baz);
        end
        // Second issue to r0: zero instance still accepts, plain instance stalls on its pending bit
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 3'd0);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL r0_reissue_model: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        n_checks++;
        if ({baz, bbz, irz, ba1, ir1} !== 5'b00110) begin
            n_fail++;
            $display("FAIL r0_never_pending: got z busy=%b%b ir=%b plain busy=%b ir=%b, want 00 1 1 0",
                     baz, bbz, irz, ba1, ir1);
        end
        drive(1'b1, 3'd0, 16'h0000, 3'd1, 3'd2, 1'b0, 3'd0);
        @(negedge clk);
        e = q.pop_front();
    endtask

    task automatic test_issue_stall();
        drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd4, 1'b1, 3'd3);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL issue_r3: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd4, 1'b1, 3'd3);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL reissue_r3: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        n_checks++;
        if ({ba1, ir1, ba0, ir0} !== 4'b1010) begin
            n_fail++;
            $display("FAIL waw_stall: got busy=%b ir=%b nb busy=%b ir=%b, want 1 0 1 0", ba1, ir1, ba0, ir0);
        end
        // Writeback of r3 with a same-cycle read
        drive(1'b1, 3'd3, 16'h00AA, 3'd3, 3'd3, 1'b0, 3'd3);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL wb_r3: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        n_checks++;
        if ({rda1, ba1, rda0, ba0, ir0} !== {16'h00AA, 1'b0, 16'h0000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL wb_r3_const: got byp a=%h busy=%b nb a=%h busy=%b ir=%b, want 00aa 0 0000 1 1",
                     rda1, ba1, rda0, ba0, ir0);
        end
        drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd5, 1'b0, 3'd3);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1, ba0, rda0} !== {e.a, e.b, e.ba, e.bb, e.ir, 1'b0, 16'h00AA}) begin
            n_fail++;
            $display("FAIL after_wb_r3: got a=%h b=%h ba=%b bb=%b ir=%b nb ba=%b a=%h, want a=%h b=%h ba=%b bb=%b ir=%b nb 0 00aa",
                     rda1, rdb1, ba1, bb1, ir1, ba0, rda0, e.a, e.b, e.ba, e.bb, e.ir);
        end
    endtask

    task automatic test_wr_iss_same();
        drive(1'b1, 3'd2, 16'h0055, 3'd1, 3'd1, 1'b1, 3'd2);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir} || ir1 !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_iss_same: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 1'b0, 3'd2);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL set_wins: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
        n_checks++;
        if ({rda1, ba1, bb1, ir1} !== {16'h0055, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL set_wins_const: got a=%h busy=%b%b ir=%b, want 0055 11 0", rda1, ba1, bb1, ir1);
        end
        // Writeback to r2 and issue to r4 in the same cycle: both take effect
        drive(1'b1, 3'd2, 16'h0066, 3'd2, 3'd4, 1'b1, 3'd4);
        @(negedge clk);
        e = q.pop_front();
        drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd4, 1'b0, 3'd0);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
            n_fail++;
            $display("FAIL wr_iss_diff: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            @(negedge clk);
            e = q.pop_front();
            n_checks++;
            if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                         i, rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
            end
        end
    endtask

    task automatic test_async_reset();
        // Clean slate with r6 written and r7 outstanding
        drive(1'b1, 3'd6, 16'hBEEF, 3'd6, 3'd7, 1'b0, 3'd0);
        @(negedge clk);
        e = q.pop_front();
        drive(1'b0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b1, 3'd7);
        @(negedge clk);
        e = q.pop_front();
        @(posedge clk);
        #1;
        iss_en = 1'b0; wr_en = 1'b0; rd_addr_a = 3'd7; rd_addr_b = 3'd6; iss_addr = 3'd7;
        #1;
        n_checks++;
        if ({ba1, rdb1, ir1} !== {1'b1, 16'hBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL pre_reset: got busy_a=%b b=%h ir=%b, want 1 beef 0", ba1, rdb1, ir1);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ba1, rdb1, ir1, ba0, rdb0, baz, rdbz} !== {1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL async_reset: got busy_a=%b b=%h ir=%b nb %b %h z %b %h, want 0 0000 1 0 0000 0 0000",
                     ba1, rdb1, ir1, ba0, rdb0, baz, rdbz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release is an ordinary cycle
        drive(1'b0, 3'd0, 16'h0, 3'd1, 3'd6, 1'b1, 3'd1);
        @(negedge clk);
        e = q.pop_front();
        drive(1'b0, 3'd0, 16'h0, 3'd1, 3'd6, 1'b0, 3'd1);
        @(negedge clk);
        e = q.pop_front();
        n_checks++;
        if ({rda1, rdb1, ba1, bb1, ir1} !== {e.a, e.b, e.ba, e.bb, e.ir} || ba1 !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_issue: got a=%h b=%h ba=%b bb=%b ir=%b, want a=%h b=%h ba=%b bb=%b ir=%b",
                     rda1, rdb1, ba1, bb1, ir1, e.a, e.b, e.ba, e.bb, e.ir);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        iss_en = 1'b0; iss_addr = '0;
        test_reset();
        test_write_read();
        test_r0_zero();
        test_issue_stall();
        test_wr_iss_same();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
